pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Interlock/flush controller for the pipelined processor top. Scoreboards in-flight
//  register writes between decode and writeback, stalls fetch/decode on RAW hazards,
//  squashes wrong-path fetch/decode on a taken jump/branch, and freezes on an external stall.
//  Sits beside fetch/decode; its outputs gate the fetch PC enable and the decode->execute register.
// PARAMETERS
//  NUM_REGS   32  architectural registers; index 0 is hardwired zero
//  WB_LAT     3   cycles from issue (decode->execute edge) to regfile write edge, >=1
//  FETCH_LAT  2   cycles of wrong-path fetch/decode to squash after jbr_taken, >=1
//  STAT_W     32  width of the stall statistics counter
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset: synchronous, active-high
//  ext_stall    in   1       stall from bench/memory; freezes the whole pipeline
//  dec_valid    in   1       decode holds a valid instruction
//  dec_rs       in   $clog2(NUM_REGS)  source reg A index
//  dec_rs_used  in   1       instruction reads rs
//  dec_rt       in   $clog2(NUM_REGS)  source reg B index
//  dec_rt_used  in   1       instruction reads rt
//  dec_r_we     in   1       instruction writes a register
//  dec_rd       in   $clog2(NUM_REGS)  destination index (after r_dst mux)
//  jbr_taken    in   1       execute resolved a taken jump/branch this cycle
//  stall_fd     out  1       hold fetch PC and the fetch->decode register
//  issue_dx     out  1       load decode->execute register; 0 = insert bubble
//  flush_fd     out  1       squash fetch and decode contents
//  stall_cnt    out  STAT_W  cycles in which stall_fd was high (saturating)
// BEHAVIOUR
//  - Reset (rst high at clk edge): delay line empty, all pending counts 0, flush counter 0,
//    stall_cnt 0. While rst is high: stall_fd=0, issue_dx=0, flush_fd=0.
//  - Scoreboard: per-register pending count, width $clog2(WB_LAT+1); register 0 never pending.
//    Delay line of WB_LAT slots {valid, rd}. On issue with dec_r_we and dec_rd!=0, push into
//    slot 0 and increment count[dec_rd]. Each unfrozen edge shifts; the valid entry leaving
//    slot WB_LAT-1 decrements its count. Simultaneous inc and dec of the same reg: unchanged.
//  - raw = dec_valid & ((dec_rs_used & dec_rs!=0 & count[dec_rs]!=0) |
//          (dec_rt_used & dec_rt!=0 & count[dec_rt]!=0)). No regfile write-through:
//    a consumer issues the cycle after the producer's entry leaves the line.
//  - Latency: producer issued in cycle t -> dependent stalls cycles t+1..t+WB_LAT,
//    issues in cycle t+WB_LAT+1 (WB_LAT stall cycles, back-to-back dependency).
//  - flushing = (flush counter != 0) | jbr_taken. jbr_taken with ext_stall low loads the
//    counter with FETCH_LAT-1; it decrements each unfrozen cycle. jbr_taken during an active
//    flush reloads it (restart). flush_fd = flushing & ~ext_stall.
//  - issue_dx = dec_valid & ~raw & ~flushing & ~ext_stall.
//  - stall_fd = ext_stall | (raw & ~flushing). A flush overrides a RAW stall (squashed insn).
//  - ext_stall high: delay line, counts, flush counter frozen; issue_dx=0; jbr_taken ignored
//    (execute holds it and re-presents it when ext_stall drops).
//  - stall_cnt increments on each cycle with stall_fd=1; saturates at all-ones.
//  - All outputs except stall_cnt are combinational from inputs and state; stall_cnt registered.
// STRUCTURE
//  - pipe_ctrl_pkg: reg_idx_t (5 bits for NUM_REGS=32), sb_entry_t {valid, rd}, REG_ZERO.
//  - Sub-module sb_delay_line (WB_LAT slots, push, freeze, retire valid/rd outputs);
//    top holds counts, flush counter, output logic and stats.
// TESTING
//  - Reset: assert rst 2 cycles mid-hazard -> next cycle count all 0, issue_dx=dec_valid, stall_cnt=0.
//  - RAW: issue r_we rd=5, next insn rs=5 -> stall_fd=1 for 3 cycles (WB_LAT=3), issue_dx=1 in 4th.
//  - Reg 0: producer rd=0, consumer rs=0 -> no stall, issue back-to-back.
//  - Double write: rd=7 issued twice consecutively, consumer rt=7 -> stalls until 2nd retires (4 cycles).
//  - Flush: jbr_taken while decode stalled on RAW -> flush_fd=1 for 2 cycles, stall_fd=0, issue_dx=0.
//  - ext_stall 5 cycles with rd=9 in slot 1 -> line frozen, consumer issues exactly 5 cycles later
//    than unstalled; stall_cnt +=5 plus RAW cycles.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_W    = $clog2(NUM_REGS);

  typedef logic [REG_W-1:0] reg_idx_t;

  // One in-flight register write travelling from issue to writeback
  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
  } sb_entry_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/sb_delay_line.sv
// Issue-to-writeback delay line: tracks which destination retires on the next unfrozen edge.
module sb_delay_line
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WB_LAT = 3
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_freeze,
  input  logic     i_push,
  input  reg_idx_t i_push_rd,
  output logic     o_ret_valid,
  output reg_idx_t o_ret_rd
);

  sb_entry_t r_slot [WB_LAT];
  sb_entry_t w_push_entry;

  // Invalid pushes carry rd 0 so idle slots stay quiet
  always_comb begin
    w_push_entry       = '0;
    w_push_entry.valid = i_push;
    w_push_entry.rd    = i_push ? i_push_rd : REG_ZERO;
  end

  // Shift one slot per unfrozen edge; slot 0 takes the newly issued write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(WB_LAT); i++) begin
        r_slot[i] <= '0;
      end
    end else if (!i_freeze) begin
      r_slot[0] <= w_push_entry;
      for (int i = 1; i < int'(WB_LAT); i++) begin
        r_slot[i] <= r_slot[i-1];
      end
    end
  end

  assign o_ret_valid = r_slot[WB_LAT-1].valid;
  assign o_ret_rd    = r_slot[WB_LAT-1].rd;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Interlock/flush controller: RAW scoreboard, branch squash, external freeze, stall stats.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WB_LAT    = 3,
  parameter int unsigned FETCH_LAT = 2,
  parameter int unsigned STAT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_stall,
  input  logic              dec_valid,
  input  reg_idx_t          dec_rs,
  input  logic              dec_rs_used,
  input  reg_idx_t          dec_rt,
  input  logic              dec_rt_used,
  input  logic              dec_r_we,
  input  reg_idx_t          dec_rd,
  input  logic              jbr_taken,
  output logic              stall_fd,
  output logic              issue_dx,
  output logic              flush_fd,
  output logic [STAT_W-1:0] stall_cnt
);

  localparam int unsigned CNT_W = $clog2(WB_LAT + 1);
  localparam int unsigned FL_W  = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;

  logic [CNT_W-1:0]  r_count [NUM_REGS];
  logic [FL_W-1:0]   r_flush_cnt;
  logic [STAT_W-1:0] r_stall_cnt;

  logic     w_rs_pend;
  logic     w_rt_pend;
  logic     w_raw;
  logic     w_flushing;
  logic     w_stall_fd;
  logic     w_issue_dx;
  logic     w_flush_fd;
  logic     w_push;
  logic     w_ret_valid;
  reg_idx_t w_ret_rd;

  // Write-in-flight tracking from issue to regfile write
  sb_delay_line #(
    .WB_LAT (WB_LAT)
  ) u_sb_delay_line (
    .clk         (clk),
    .rst         (rst),
    .i_freeze    (ext_stall),
    .i_push      (w_push),
    .i_push_rd   (dec_rd),
    .o_ret_valid (w_ret_valid),
    .o_ret_rd    (w_ret_rd)
  );

  // Hazard detection and pipeline control; everything low while in reset
  always_comb begin
    w_rs_pend  = dec_rs_used && (dec_rs != REG_ZERO) && (r_count[dec_rs] != '0);
    w_rt_pend  = dec_rt_used && (dec_rt != REG_ZERO) && (r_count[dec_rt] != '0);
    w_raw      = dec_valid && (w_rs_pend || w_rt_pend);
    w_flushing = (r_flush_cnt != '0) || jbr_taken;
    w_stall_fd = 1'b0;
    w_issue_dx = 1'b0;
    w_flush_fd = 1'b0;
    if (!rst) begin
      w_issue_dx = dec_valid && !w_raw && !w_flushing && !ext_stall;
      w_stall_fd = ext_stall || (w_raw && !w_flushing);
      w_flush_fd = w_flushing && !ext_stall;
    end
    w_push = w_issue_dx && dec_r_we && (dec_rd != REG_ZERO);
  end

  // Per-register pending-write counts; an inc and dec of the same reg cancel
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_count[i] <= '0;
      end
    end else if (!ext_stall) begin
      r_count[0] <= '0;
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        if (w_push && (dec_rd == reg_idx_t'(i)) &&
            !(w_ret_valid && (w_ret_rd == reg_idx_t'(i)))) begin
          r_count[i] <= r_count[i] + CNT_W'(1);
        end else if (w_ret_valid && (w_ret_rd == reg_idx_t'(i)) &&
                     !(w_push && (dec_rd == reg_idx_t'(i)))) begin
          r_count[i] <= r_count[i] - CNT_W'(1);
        end
      end
    end
  end

  // Wrong-path squash window; a new taken branch restarts it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_cnt <= '0;
    end else if (!ext_stall) begin
      if (jbr_taken) begin
        r_flush_cnt <= FL_W'(FETCH_LAT - 1);
      end else if (r_flush_cnt != '0) begin
        r_flush_cnt <= r_flush_cnt - FL_W'(1);
      end
    end
  end

  // Saturating count of cycles with fetch/decode held
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall_fd && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STAT_W'(1);
    end
  end

  assign stall_fd  = w_stall_fd;
  assign issue_dx  = w_issue_dx;
  assign flush_fd  = w_flush_fd;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed hazard scenarios plus random traffic against a reference model.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int WB_LAT    = 3;
  localparam int FETCH_LAT = 2;
  localparam int STAT_W    = 8;
  localparam longint SC_MAX = (64'd1 << STAT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              ext_stall;
  logic              dec_valid;
  reg_idx_t          dec_rs;
  logic              dec_rs_used;
  reg_idx_t          dec_rt;
  logic              dec_rt_used;
  logic              dec_r_we;
  reg_idx_t          dec_rd;
  logic              jbr_taken;
  logic              stall_fd;
  logic              issue_dx;
  logic              flush_fd;
  logic [STAT_W-1:0] stall_cnt;

  pipe_hazard_ctrl #(
    .WB_LAT    (WB_LAT),
    .FETCH_LAT (FETCH_LAT),
    .STAT_W    (STAT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ext_stall   (ext_stall),
    .dec_valid   (dec_valid),
    .dec_rs      (dec_rs),
    .dec_rs_used (dec_rs_used),
    .dec_rt      (dec_rt),
    .dec_rt_used (dec_rt_used),
    .dec_r_we    (dec_r_we),
    .dec_rd      (dec_rd),
    .jbr_taken   (jbr_taken),
    .stall_fd    (stall_fd),
    .issue_dx    (issue_dx),
    .flush_fd    (flush_fd),
    .stall_cnt   (stall_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: list of outstanding writes with remaining unfrozen edges to writeback
  int     pend_rd[$];
  int     pend_rem[$];
  int     m_flush_left = 0;
  longint m_sc = 0;
  int     cyc = 0;

  logic              seen_issue;
  logic              seen_flush;
  logic              seen_stall;
  logic [STAT_W-1:0] seen_sc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit m_pending(input reg_idx_t r);
    if (r == REG_ZERO) return 1'b0;
    foreach (pend_rd[i]) begin
      if (pend_rd[i] == int'(r)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock: inputs already applied at negedge; check, clock, advance the model
  task automatic step();
    bit e_raw, e_fl, e_iss, e_stl, e_ffd;
    int nrd[$];
    int nrem[$];
    #1;
    e_raw = dec_valid && ((dec_rs_used && m_pending(dec_rs)) ||
                          (dec_rt_used && m_pending(dec_rt)));
    e_fl  = (m_flush_left > 0) || jbr_taken;
    e_iss = dec_valid && !e_raw && !e_fl && !ext_stall;
    e_stl = ext_stall || (e_raw && !e_fl);
    e_ffd = e_fl && !ext_stall;
    if (rst) begin
      e_iss = 1'b0;
      e_stl = 1'b0;
      e_ffd = 1'b0;
    end
    chk("stall_fd", 64'(stall_fd), 64'(e_stl));
    chk("issue_dx", 64'(issue_dx), 64'(e_iss));
    chk("flush_fd", 64'(flush_fd), 64'(e_ffd));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_sc));
    seen_issue = issue_dx;
    seen_flush = flush_fd;
    seen_stall = stall_fd;
    seen_sc    = stall_cnt;
    @(posedge clk);
    if (rst) begin
      pend_rd.delete();
      pend_rem.delete();
      m_flush_left = 0;
      m_sc = 0;
    end else begin
      if (e_stl && m_sc < SC_MAX) m_sc++;
      if (!ext_stall) begin
        foreach (pend_rd[i]) begin
          if (pend_rem[i] > 1) begin
            nrd.push_back(pend_rd[i]);
            nrem.push_back(pend_rem[i] - 1);
          end
        end
        pend_rd  = nrd;
        pend_rem = nrem;
        if (e_iss && dec_r_we && dec_rd != REG_ZERO) begin
          pend_rd.push_back(int'(dec_rd));
          pend_rem.push_back(WB_LAT);
        end
        if (jbr_taken) m_flush_left = FETCH_LAT - 1;
        else if (m_flush_left > 0) m_flush_left--;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_insn(input logic v, input int rs, input logic rsu, input int rt,
                          input logic rtu, input logic we, input int rd);
    dec_valid   = v;
    dec_rs      = reg_idx_t'(rs);
    dec_rs_used = rsu;
    dec_rt      = reg_idx_t'(rt);
    dec_rt_used = rtu;
    dec_r_we    = we;
    dec_rd      = reg_idx_t'(rd);
  endtask

  task automatic idle(input int n);
    rst = 1'b0; ext_stall = 1'b0; jbr_taken = 1'b0;
    set_insn(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
    repeat (n) step();
  endtask

  // Hold the current consumer until it issues; returns stall cycles and issue cycle
  task automatic wait_issue(output int n, output int c_iss);
    n = 0;
    c_iss = -1;
    while (n < 50) begin
      c_iss = cyc;
      step();
      if (seen_issue) break;
      n++;
    end
  endtask

  function automatic int pick_reg();
    int sel;
    sel = int'($urandom_range(0, 5));
    case (sel)
      0: return 0;
      1: return 5;
      2: return 7;
      3: return 9;
      default: return int'($urandom_range(0, NUM_REGS - 1));
    endcase
  endfunction

  initial begin
    int n, c_prod, c_iss, nf, sc0, ext_left, rst_left;

    rst = 1'b1; ext_stall = 1'b0; jbr_taken = 1'b0;
    set_insn(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
    @(negedge clk);
    step();
    step();

    // Reset mid-hazard: consumer free to issue right after
    rst = 1'b0;
    set_insn(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 5);
    step();
    set_insn(1'b1, 5, 1'b1, 0, 1'b0, 1'b0, 0);
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_issue", 64'(seen_issue), 64'd1);
    chk("rst_stall_cnt", 64'(seen_sc), 64'd0);
    idle(6);

    // RAW back-to-back dependency
    set_insn(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 5);
    step();
    set_insn(1'b1, 5, 1'b1, 0, 1'b0, 1'b0, 0);
    wait_issue(n, c_iss);
    chk("raw_stall_cycles", 64'(n), 64'(WB_LAT));
    idle(6);

    // Register 0 never creates a hazard
    set_insn(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 0);
    step();
    set_insn(1'b1, 0, 1'b1, 0, 1'b1, 1'b0, 0);
    step();
    chk("reg0_back_to_back", 64'(seen_issue), 64'd1);
    idle(6);

    // Two writes to r7 in a row: consumer waits for the second
    set_insn(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 7);
    step();
    c_prod = cyc;
    step();
    set_insn(1'b1, 0, 1'b0, 7, 1'b1, 1'b0, 0);
    wait_issue(n, c_iss);
    chk("dbl_write_latency", 64'(c_iss - c_prod), 64'(WB_LAT + 1));
    idle(6);

    // Taken branch while decode is RAW-stalled
    set_insn(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 5);
    step();
    set_insn(1'b1, 5, 1'b1, 0, 1'b0, 1'b0, 0);
    step();
    jbr_taken = 1'b1;
    step();
    chk("flush_no_stall", 64'(seen_stall), 64'd0);
    chk("flush_no_issue", 64'(seen_issue), 64'd0);
    nf = int'(seen_flush);
    jbr_taken = 1'b0;
    repeat (3) begin
      step();
      nf += int'(seen_flush);
    end
    chk("flush_len", 64'(nf), 64'(FETCH_LAT));
    idle(6);

    // External stall freezes an in-flight write in slot 1
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    sc0 = int'(stall_cnt);
    set_insn(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 9);
    c_prod = cyc;
    step();
    set_insn(1'b1, 9, 1'b1, 0, 1'b0, 1'b0, 0);
    step();
    ext_stall = 1'b1;
    repeat (5) step();
    ext_stall = 1'b0;
    wait_issue(n, c_iss);
    chk("ext_stall_latency", 64'(c_iss - c_prod), 64'(WB_LAT + 1 + 5));
    chk("ext_stall_cnt", 64'(int'(stall_cnt) - sc0), 64'(WB_LAT + 5));
    idle(6);

    // Random traffic against the model
    ext_left = 0;
    rst_left = 0;
    for (int k = 0; k < 4000; k++) begin
      if (rst_left == 0 && $urandom_range(0, 499) == 0) rst_left = 2;
      rst = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      if (ext_left == 0 && $urandom_range(0, 9) == 0) ext_left = int'($urandom_range(1, 6));
      ext_stall = (ext_left > 0);
      if (ext_left > 0) ext_left--;
      jbr_taken = ($urandom_range(0, 15) == 0);
      set_insn($urandom_range(0, 7) != 0, pick_reg(), 1'($urandom_range(0, 1)),
               pick_reg(), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, pick_reg());
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
